// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRC command encodings, line-port state type and tie-off values
package sdram_pkg;

  localparam logic [2:0] CmdActivate = 3'b011;
  localparam logic [2:0] CmdWrite    = 3'b100;
  localparam logic [2:0] CmdRead     = 3'b101;

  localparam logic [3:0] DqmTie           = 4'b0000;
  localparam logic       PrechargeCtrlTie = 1'b1;
  localparam logic       PowerDownTie     = 1'b0;
  localparam logic       SelfRefreshTie   = 1'b0;

  // ActWait cycles without an ack before a request is abandoned
  localparam int AckTimeoutCycles = 255;

  typedef enum logic [3:0] {
    Init,
    Idle,
    Activate,
    ActWait,
    WriteBeat,
    WriteRecover,
    ReadCmd,
    ReadWait,
    ReadBeat,
    Done
  } state_e;

endpackage

// File: rtl/sdram_line_port.sv
// rtl/sdram_line_port.sv - whole-line burst adapter to the SDRC; option SDRAM_LINE_PORT_ACK_TIMEOUT_EN adds the timeout port
module sdram_line_port
  import sdram_pkg::*;
#(
  parameter int AddressBitWidth        = 21,
  parameter int ColumnCount            = 8,
  parameter int WaitsAfterBurstWrite   = 10,
  parameter int WaitsPriorToDataAtRead = 3,
  localparam int ColumnBits            = $clog2(ColumnCount)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [AddressBitWidth-1:0] req_address,
  output logic [ColumnBits-1:0]      wr_column,
  input  logic [31:0]                wr_data,
  output logic                       rd_valid,
  output logic [ColumnBits-1:0]      rd_column,
  output logic [31:0]                rd_data,
  output logic                       done,
`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
  output logic                       timeout,
`endif
  output logic                       I_sdrc_cmd_en,
  output logic [2:0]                 I_sdrc_cmd,
  output logic [AddressBitWidth-1:0] I_sdrc_addr,
  output logic [31:0]                I_sdrc_data,
  output logic [7:0]                 I_sdrc_data_len,
  output logic [3:0]                 I_sdrc_dqm,
  output logic                       I_sdrc_precharge_ctrl,
  output logic                       I_sdram_power_down,
  output logic                       I_sdram_selfrefresh,
  input  logic [31:0]                O_sdrc_data,
  input  logic                       O_sdrc_init_done,
  input  logic                       O_sdrc_cmd_ack
);

  localparam int         CntWidth = 16;
  localparam logic [7:0] DataLen  = 8'(ColumnCount - 1);

  assign I_sdrc_dqm            = DqmTie;
  assign I_sdrc_precharge_ctrl = PrechargeCtrlTie;
  assign I_sdram_power_down    = PowerDownTie;
  assign I_sdram_selfrefresh   = SelfRefreshTie;

  state_e                     state_q, state_d;
  logic                       write_q, write_d;
  logic [CntWidth-1:0]        cnt_q, cnt_d;
  logic                       req_ready_d, done_d;
  logic                       cmd_en_d;
  logic [2:0]                 cmd_d;
  logic [AddressBitWidth-1:0] addr_d;
  logic [31:0]                data_d;
  logic [7:0]                 len_d;
  logic [ColumnBits-1:0]      wr_column_d, rd_column_d;
  logic                       rd_valid_d;
  logic [31:0]                rd_data_d;
`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
  logic                       timeout_set;
`endif

  // Next state and next registered-output values; wr_column doubles as the write beat index
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    cmd_en_d    = 1'b0;
    cmd_d       = I_sdrc_cmd;
    addr_d      = I_sdrc_addr;
    data_d      = I_sdrc_data;
    len_d       = I_sdrc_data_len;
    wr_column_d = wr_column;
    rd_valid_d  = 1'b0;
    rd_column_d = rd_column;
    rd_data_d   = rd_data;
`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    case (state_q)
      Init: begin
        if (O_sdrc_init_done) state_d = Idle;
      end
      Idle: begin
        if (req_valid && req_ready) begin
          write_d     = req_write;
          addr_d      = req_address;
          wr_column_d = '0;
          cmd_en_d    = 1'b1;
          cmd_d       = CmdActivate;
          state_d     = Activate;
        end
      end
      Activate: begin
        cnt_d   = '0;
        state_d = ActWait;
      end
      ActWait: begin
        if (O_sdrc_cmd_ack) begin
          cnt_d    = '0;
          cmd_en_d = 1'b1;
          len_d    = DataLen;
          if (write_q) begin
            cmd_d       = CmdWrite;
            data_d      = wr_data;
            wr_column_d = wr_column + 1'b1;
            state_d     = WriteBeat;
          end else begin
            cmd_d   = CmdRead;
            state_d = ReadCmd;
          end
        end
`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
        else if (cnt_q == CntWidth'(AckTimeoutCycles - 1)) begin
          timeout_set = 1'b1;
          state_d     = Done;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WriteBeat: begin
        // wr_column has wrapped to 0 during the last beat
        if (wr_column == '0) begin
          cnt_d   = '0;
          state_d = (WaitsAfterBurstWrite == 0) ? Done : WriteRecover;
        end else begin
          data_d      = wr_data;
          wr_column_d = wr_column + 1'b1;
        end
      end
      WriteRecover: begin
        if (cnt_q == CntWidth'(WaitsAfterBurstWrite - 1)) state_d = Done;
        else cnt_d = cnt_q + 1'b1;
      end
      ReadCmd: begin
        cnt_d   = '0;
        state_d = (WaitsPriorToDataAtRead > 1) ? ReadWait : ReadBeat;
      end
      ReadWait: begin
        if (cnt_q == CntWidth'(WaitsPriorToDataAtRead - 2)) begin
          cnt_d   = '0;
          state_d = ReadBeat;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ReadBeat: begin
        rd_valid_d  = 1'b1;
        rd_data_d   = O_sdrc_data;
        rd_column_d = cnt_q[ColumnBits-1:0];
        if (cnt_q == CntWidth'(ColumnCount - 1)) state_d = Done;
        else cnt_d = cnt_q + 1'b1;
      end
      Done: begin
        state_d = Idle;
      end
      default: begin
        state_d = Init;
      end
    endcase
    req_ready_d = (state_d == Idle);
    done_d      = (state_d == Done);
  end

  // State register and every registered output; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= Init;
      write_q         <= 1'b0;
      cnt_q           <= '0;
      req_ready       <= 1'b0;
      done            <= 1'b0;
      I_sdrc_cmd_en   <= 1'b0;
      I_sdrc_cmd      <= '0;
      I_sdrc_addr     <= '0;
      I_sdrc_data     <= '0;
      I_sdrc_data_len <= '0;
      wr_column       <= '0;
      rd_valid        <= 1'b0;
      rd_column       <= '0;
      rd_data         <= '0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      cnt_q           <= cnt_d;
      req_ready       <= req_ready_d;
      done            <= done_d;
      I_sdrc_cmd_en   <= cmd_en_d;
      I_sdrc_cmd      <= cmd_d;
      I_sdrc_addr     <= addr_d;
      I_sdrc_data     <= data_d;
      I_sdrc_data_len <= len_d;
      wr_column       <= wr_column_d;
      rd_valid        <= rd_valid_d;
      rd_column       <= rd_column_d;
      rd_data         <= rd_data_d;
    end
  end

`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
  // Sticky flag recording that some request was abandoned for lack of an ack
  always_ff @(posedge clk) begin
    if (rst) timeout <= 1'b0;
    else if (timeout_set) timeout <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sdram_line_port.sv
// tb/tb_sdram_line_port.sv - directed bench for sdram_line_port with a small SDRC model
module tb_sdram_line_port;
  import sdram_pkg::*;

  localparam int AW = 21;
  localparam int CC = 8;
  localparam int WW = 10;
  localparam int WR = 3;
  localparam int CB = $clog2(CC);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [CB-1:0] wr_column, rd_column;
  logic [31:0]   wr_data, rd_data;
  logic          rd_valid, done;
  logic          I_sdrc_cmd_en;
  logic [2:0]    I_sdrc_cmd;
  logic [AW-1:0] I_sdrc_addr;
  logic [31:0]   I_sdrc_data;
  logic [7:0]    I_sdrc_data_len;
  logic [3:0]    I_sdrc_dqm;
  logic          I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh;
  logic [31:0]   O_sdrc_data;
  logic          O_sdrc_init_done, O_sdrc_cmd_ack;
`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
  logic          timeout;
  logic          done_timeout;
`endif

  always #5 clk = ~clk;

  // client column registers: word for column c is 0xB000_0000 + c
  assign wr_data = 32'hB000_0000 + 32'(wr_column);

  sdram_line_port #(
    .AddressBitWidth(AW), .ColumnCount(CC),
    .WaitsAfterBurstWrite(WW), .WaitsPriorToDataAtRead(WR)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_address(req_address),
    .wr_column(wr_column), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_column(rd_column), .rd_data(rd_data),
    .done(done),
`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
    .timeout(timeout),
`endif
    .I_sdrc_cmd_en(I_sdrc_cmd_en), .I_sdrc_cmd(I_sdrc_cmd), .I_sdrc_addr(I_sdrc_addr),
    .I_sdrc_data(I_sdrc_data), .I_sdrc_data_len(I_sdrc_data_len),
    .I_sdrc_dqm(I_sdrc_dqm), .I_sdrc_precharge_ctrl(I_sdrc_precharge_ctrl),
    .I_sdram_power_down(I_sdram_power_down), .I_sdram_selfrefresh(I_sdram_selfrefresh),
    .O_sdrc_data(O_sdrc_data), .O_sdrc_init_done(O_sdrc_init_done), .O_sdrc_cmd_ack(O_sdrc_cmd_ack)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          ack_dly = 2;
  logic        ack_en = 1'b1;
  logic [31:0] rd_base = 32'hA0;
  int          act_cyc, rdcmd_cyc, wrcmd_cyc;
  logic [AW-1:0] act_addr;
  logic [7:0]  rd_len, wr_len;

  logic [2:0]    cmd_log[$];
  int            cmd_cyc[$];
  logic [31:0]   wr_beats[$];
  int            rd_col_log[$];
  logic [31:0]   rd_dat_log[$];
  int            rd_cyc_log[$];
  int            done_log[$];
  int            acc_log[$];
  logic          pend_write[$];
  logic [AW-1:0] pend_addr[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    act_cyc = -1; rdcmd_cyc = -1; wrcmd_cyc = -1;
    cmd_log.delete(); cmd_cyc.delete(); wr_beats.delete();
    rd_col_log.delete(); rd_dat_log.delete(); rd_cyc_log.delete();
    done_log.delete(); acc_log.delete();
  endtask

  task automatic submit(input logic w, input logic [AW-1:0] a);
    if (!req_valid) begin
      req_valid = 1'b1; req_write = w; req_address = a;
    end else begin
      pend_write.push_back(w); pend_addr.push_back(a);
    end
  endtask

  // one clock: note the handshake at the edge, log DUT outputs, then drive the SDRC model
  task automatic tick();
    logic hs;
    hs = req_valid && req_ready && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      acc_log.push_back(cyc - 1);
      if (pend_addr.size() > 0) begin
        req_write = pend_write.pop_front(); req_address = pend_addr.pop_front();
      end else begin
        req_valid = 1'b0;
      end
    end
    if (I_sdrc_cmd_en) begin
      cmd_log.push_back(I_sdrc_cmd); cmd_cyc.push_back(cyc);
      if (I_sdrc_cmd == 3'b011) begin act_cyc = cyc; act_addr = I_sdrc_addr; end
      if (I_sdrc_cmd == 3'b101) begin rdcmd_cyc = cyc; rd_len = I_sdrc_data_len; end
      if (I_sdrc_cmd == 3'b100) begin wrcmd_cyc = cyc; wr_len = I_sdrc_data_len; end
    end
    if (wrcmd_cyc >= 0 && cyc - wrcmd_cyc < CC) wr_beats.push_back(I_sdrc_data);
    if (rd_valid) begin
      rd_col_log.push_back(int'(rd_column)); rd_dat_log.push_back(rd_data); rd_cyc_log.push_back(cyc);
    end
    if (done) begin
      done_log.push_back(cyc);
`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
      done_timeout = timeout;
`endif
    end
    O_sdrc_cmd_ack = ack_en && act_cyc >= 0 && cyc == act_cyc + ack_dly;
    if (rdcmd_cyc >= 0 && cyc - rdcmd_cyc >= WR && cyc - rdcmd_cyc < WR + CC)
      O_sdrc_data = rd_base + 32'(cyc - rdcmd_cyc - WR);
    else
      O_sdrc_data = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int k = 0;
    while (done_log.size() < n && k < budget) begin tick(); k++; end
    check({tag, "_done_seen"}, 64'(done_log.size() >= n), 1);
  endtask

  task automatic check_read(input string tag, input logic [31:0] base);
    check({tag, "_rd_count"}, 64'(rd_col_log.size()), CC);
    for (int k = 0; k < CC; k++) begin
      check($sformatf("%s_rd_col%0d", tag, k), 64'(rd_col_log[k]), 64'(k));
      check($sformatf("%s_rd_data%0d", tag, k), 64'(rd_dat_log[k]), 64'(base + 32'(k)));
      check($sformatf("%s_rd_cyc%0d", tag, k), 64'(rd_cyc_log[k] - rdcmd_cyc), 64'(WR + 1 + k));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_rdy, cnt_cmd, rr_cyc, guard;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0;
    O_sdrc_data = '0; O_sdrc_init_done = 1'b0; O_sdrc_cmd_ack = 1'b0;
    clear_logs();
    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_cmd_en", I_sdrc_cmd_en, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_column", wr_column, 0);
    check("rst_addr", I_sdrc_addr, 0);
    check("rst_data_len", I_sdrc_data_len, 0);
    check("tie_dqm", I_sdrc_dqm, 4'b0000);
    check("tie_precharge", I_sdrc_precharge_ctrl, 1);
    check("tie_power_down", I_sdram_power_down, 0);
    check("tie_selfrefresh", I_sdram_selfrefresh, 0);
`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
    check("rst_timeout", timeout, 0);
`endif
    rst = 1'b0;

    // init gating, then the first read line at 0x100
    submit(1'b0, 21'h000100);
    cnt_rdy = 0; cnt_cmd = 0;
    repeat (20) begin tick(); cnt_rdy += int'(req_ready); cnt_cmd += int'(I_sdrc_cmd_en); end
    check("init_req_ready_low", 64'(cnt_rdy), 0);
    check("init_no_cmd_en", 64'(cnt_cmd), 0);
    O_sdrc_init_done = 1'b1;
    guard = 0;
    while (!req_ready && guard < 10) begin tick(); guard++; end
    check("init_ready_rises", req_ready, 1);
    rr_cyc = cyc;
    wait_done("rd1", 1, 100);
    check("rd1_act_after_ready", 64'(act_cyc - rr_cyc), 1);
    check("rd1_cmd_count", 64'(cmd_log.size()), 2);
    check("rd1_cmd0", cmd_log[0], 3'b011);
    check("rd1_cmd1", cmd_log[1], 3'b101);
    check("rd1_addr", act_addr, 21'h000100);
    check("rd1_len", rd_len, 7);
    check("rd1_cmd_gap", 64'(rdcmd_cyc - act_cyc), 3);
    check_read("rd1", 32'hA0);
    check("rd1_latency", 64'(done_log[0] - acc_log[0]), 64'(3 + WR + CC + 1));
    repeat (3) tick();
    check("rd1_done_once", 64'(done_log.size()), 1);

    // write line at 0x200
    clear_logs();
    submit(1'b1, 21'h000200);
    wait_done("wr1", 1, 100);
    repeat (3) tick();
    check("wr1_cmd_count", 64'(cmd_log.size()), 2);
    check("wr1_cmd1", cmd_log[1], 3'b100);
    check("wr1_addr", act_addr, 21'h000200);
    check("wr1_len", wr_len, 7);
    check("wr1_beats", 64'(wr_beats.size()), CC);
    for (int k = 0; k < CC; k++)
      check($sformatf("wr1_data%0d", k), wr_beats[k], 64'(32'hB000_0000 + 32'(k)));
    check("wr1_done_after_last", 64'(done_log[0] - (wrcmd_cyc + CC - 1)), WW + 1);
    check("wr1_latency", 64'(done_log[0] - acc_log[0]), 64'(3 + CC + WW + 1));
    check("wr1_done_once", 64'(done_log.size()), 1);
    check("wr1_no_rd_valid", 64'(rd_col_log.size()), 0);

    // back-to-back write then read
    clear_logs();
    rd_base = 32'hD0;
    submit(1'b1, 21'h000300);
    submit(1'b0, 21'h000400);
    wait_done("b2b", 2, 200);
    check("b2b_cmd_count", 64'(cmd_log.size()), 4);
    check("b2b_cmd0", cmd_log[0], 3'b011);
    check("b2b_cmd1", cmd_log[1], 3'b100);
    check("b2b_cmd2", cmd_log[2], 3'b011);
    check("b2b_cmd3", cmd_log[3], 3'b101);
    check("b2b_act_after_done", 64'(cmd_cyc[2] > done_log[0]), 1);
    check("b2b_gap_le2", 64'(cmd_cyc[2] - done_log[0] <= 2), 1);
    check("b2b_addr2", act_addr, 21'h000400);
    check_read("b2b", 32'hD0);

    // reset during write beat 3
    clear_logs();
    submit(1'b1, 21'h000600);
    guard = 0;
    while (!(wrcmd_cyc >= 0 && cyc == wrcmd_cyc + 3) && guard < 60) begin tick(); guard++; end
    check("mid_reach_beat3", 64'(wrcmd_cyc >= 0 && cyc == wrcmd_cyc + 3), 1);
    check("mid_beat3_data", I_sdrc_data, 32'hB000_0003);
    rst = 1'b1; O_sdrc_init_done = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_cmd_en_low", I_sdrc_cmd_en, 0);
    check("mid_req_ready_low", req_ready, 0);
    check("mid_wr_column", wr_column, 0);
    repeat (4) tick();
    check("mid_still_init", req_ready, 0);
    O_sdrc_init_done = 1'b1;
    repeat (20) tick();
    check("mid_no_done", 64'(done_log.size()), 0);
    clear_logs();
    rd_base = 32'hE0;
    submit(1'b0, 21'h000500);
    wait_done("rd2", 1, 100);
    check("rd2_addr", act_addr, 21'h000500);
    check_read("rd2", 32'hE0);

`ifdef SDRAM_LINE_PORT_ACK_TIMEOUT_EN
    // SDRC never acks
    repeat (3) tick();
    clear_logs();
    ack_en = 1'b0;
    submit(1'b0, 21'h000700);
    wait_done("to", 1, 400);
    check("to_done_delay", 64'(done_log[0] - act_cyc), 256);
    check("to_flag_at_done", done_timeout, 1);
    check("to_no_rd_valid", 64'(rd_col_log.size()), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("to_cleared_by_rst", timeout, 0);
    ack_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
